// File: rtl/spart_pkg.sv
// Shared constants and types for the SPART bus controller.
package spart_pkg;

  // Processor I/O address map
  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DBL    = 2'b10;
  localparam logic [1:0] ADDR_DBH    = 2'b11;

  // Bit positions inside the status byte
  localparam int unsigned STAT_TBR    = 0;
  localparam int unsigned STAT_RDA    = 1;
  localparam int unsigned STAT_TXDROP = 2;

  // Receiver read-clear handshake states
  typedef enum logic {
    S_IDLE,
    S_CLR_WAIT
  } rx_clr_state_e;

endpackage

// File: rtl/spart_ctrl_if.sv
// Processor I/O port of the SPART: chip select, direction, address, data.
interface spart_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              i_iocs;
  logic              i_iorw;
  logic [1:0]        i_ioaddr;
  logic [DATA_W-1:0] i_wdata;
  logic [DATA_W-1:0] o_rdata;

  modport master (
    output i_iocs, i_iorw, i_ioaddr, i_wdata,
    input  o_rdata
  );

  modport slave (
    input  i_iocs, i_iorw, i_ioaddr, i_wdata,
    output o_rdata
  );
endinterface

// File: rtl/spart_baud_gen.sv
// 16x-oversample baud tick generator: programmable down-counter.
module spart_baud_gen #(
  parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_divisor,
  input  logic        i_reload,
  output logic        o_b_en
);

  logic [15:0] r_cnt;
  logic        r_b_en;

  // Count down to zero, emit a one-cycle tick and reload; a reload restarts the period.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= DEFAULT_DIV;
      r_b_en <= 1'b0;
    end else if (i_reload) begin
      r_cnt  <= i_divisor;
      r_b_en <= 1'b0;
    end else if (r_cnt == '0) begin
      r_cnt  <= i_divisor;
      r_b_en <= 1'b1;
    end else begin
      r_cnt  <= r_cnt - 16'd1;
      r_b_en <= 1'b0;
    end
  end

  assign o_b_en = r_b_en;

endmodule

// File: rtl/spart_ctrl.sv
// SPART bus-side controller: I/O decode, divisor registers, TX load, RX read-clear stretch.
module spart_ctrl
  import spart_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIV = 16'd325,
  parameter int          DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  spart_ctrl_if.slave       bus,
  output logic              o_b_en,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rda,
  output logic              o_rx_iocs,
  output logic              o_rx_iorw,
  input  logic              i_tbr,
  output logic              o_tx_load,
  output logic [DATA_W-1:0] o_tx_data
);

  logic              w_rd;
  logic              w_wr;
  logic              w_data_rd;
  logic              w_stat_rd;
  logic              w_tx_wr;
  logic              w_dbl_wr;
  logic              w_dbh_wr;
  logic [15:0]       w_new_div;
  logic [15:0]       w_div_sel;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_rdata;

  logic [15:0]       r_div;
  logic [7:0]        r_dbl;
  logic              r_tx_load;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_drop;
  rx_clr_state_e     r_state;
  rx_clr_state_e     w_state_nxt;

  // Access decode; nothing happens unless chip select is asserted.
  always_comb begin
    w_rd      = bus.i_iocs & bus.i_iorw;
    w_wr      = bus.i_iocs & ~bus.i_iorw;
    w_data_rd = w_rd & (bus.i_ioaddr == ADDR_DATA);
    w_stat_rd = w_rd & (bus.i_ioaddr == ADDR_STATUS);
    w_tx_wr   = w_wr & (bus.i_ioaddr == ADDR_DATA);
    w_dbl_wr  = w_wr & (bus.i_ioaddr == ADDR_DBL);
    w_dbh_wr  = w_wr & (bus.i_ioaddr == ADDR_DBH);
    w_new_div = {bus.i_wdata[7:0], r_dbl};
    // The counter sees the new divisor in the same edge the DBH write commits it.
    w_div_sel = w_dbh_wr ? w_new_div : r_div;
  end

  // Divisor: DBL only fills the shadow, DBH commits both halves together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div <= DEFAULT_DIV;
      r_dbl <= '0;
    end else if (w_dbl_wr) begin
      r_dbl <= bus.i_wdata[7:0];
    end else if (w_dbh_wr) begin
      r_div <= w_new_div;
    end
  end

  spart_baud_gen #(
    .DEFAULT_DIV(DEFAULT_DIV)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .i_divisor (w_div_sel),
    .i_reload  (w_dbh_wr),
    .o_b_en    (o_b_en)
  );

  // TX path: accept a byte only when the transmitter buffer is ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_load <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_tx_load <= w_tx_wr & i_tbr;
      if (w_tx_wr & i_tbr) begin
        r_tx_data <= bus.i_wdata;
      end
    end
  end

  // Sticky dropped-write flag; a new drop outranks the clear from a status read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_drop <= 1'b0;
    end else if (w_tx_wr & ~i_tbr) begin
      r_tx_drop <= 1'b1;
    end else if (w_stat_rd) begin
      r_tx_drop <= 1'b0;
    end
  end

  // RX read-clear state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Hold the clear strobe until the receiver has seen one baud tick.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_data_rd && i_rda) w_state_nxt = S_CLR_WAIT;
      S_CLR_WAIT: if (o_b_en)             w_state_nxt = S_IDLE;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  assign o_rx_iocs = (r_state == S_CLR_WAIT);
  assign o_rx_iorw = (r_state == S_CLR_WAIT);
  assign o_tx_load = r_tx_load;
  assign o_tx_data = r_tx_data;

  // Read data mux; zero whenever no read is in progress.
  always_comb begin
    w_status              = '0;
    w_status[STAT_TBR]    = i_tbr;
    w_status[STAT_RDA]    = i_rda;
    w_status[STAT_TXDROP] = r_tx_drop;
    w_rdata               = '0;
    if (w_rd) begin
      case (bus.i_ioaddr)
        ADDR_DATA:   w_rdata = i_rx_data;
        ADDR_STATUS: w_rdata = w_status;
        ADDR_DBL:    w_rdata = DATA_W'(r_div[7:0]);
        ADDR_DBH:    w_rdata = DATA_W'(r_div[15:8]);
        default:     w_rdata = '0;
      endcase
    end
  end

  assign bus.o_rdata = w_rdata;

endmodule

// File: tb/tb_spart_ctrl.sv
// Self-checking bench for spart_ctrl: cycle model plus directed and random stimulus.
module tb_spart_ctrl;
  import spart_pkg::*;

  localparam int          DW  = 8;
  localparam logic [15:0] DEF = 16'd325;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rda;
  logic          tbr;
  logic          b_en;
  logic          rx_iocs;
  logic          rx_iorw;
  logic          tx_load;
  logic [DW-1:0] tx_data;

  spart_ctrl_if #(.DATA_W(DW)) bus ();

  spart_ctrl #(.DEFAULT_DIV(DEF), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .o_b_en    (b_en),
    .i_rx_data (rx_data),
    .i_rda     (rda),
    .o_rx_iocs (rx_iocs),
    .o_rx_iorw (rx_iorw),
    .i_tbr     (tbr),
    .o_tx_load (tx_load),
    .o_tx_data (tx_data)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Tick schedule is kept as an absolute edge number of the next tick.
  longint      m_edge = 0;
  longint      m_next = 0;
  logic [15:0] m_div;
  logic [7:0]  m_dbl;
  bit          m_ben, m_txload, m_drop, m_clr, m_valid = 0;
  logic [7:0]  m_txdata;

  always @(posedge clk) begin
    bit wr, rd;
    m_edge++;
    if (!rst) begin
      m_valid = 1; m_div = DEF; m_dbl = 8'h00; m_next = m_edge + longint'(DEF) + 1;
      m_ben = 0; m_txload = 0; m_txdata = 8'h00; m_drop = 0; m_clr = 0;
    end else if (m_valid) begin
      wr = bus.i_iocs && !bus.i_iorw;
      rd = bus.i_iocs && bus.i_iorw;
      if (m_clr) begin
        if (m_ben) m_clr = 0;
      end else if (rd && bus.i_ioaddr == 2'd0 && rda) m_clr = 1;
      if (wr && bus.i_ioaddr == 2'd0 && !tbr) m_drop = 1;
      else if (rd && bus.i_ioaddr == 2'd1) m_drop = 0;
      m_txload = wr && bus.i_ioaddr == 2'd0 && tbr;
      if (m_txload) m_txdata = bus.i_wdata;
      if (wr && bus.i_ioaddr == 2'd2) m_dbl = bus.i_wdata;
      if (wr && bus.i_ioaddr == 2'd3) begin
        m_div  = {bus.i_wdata, m_dbl};
        m_next = m_edge + longint'(m_div) + 1;
        m_ben  = 0;
      end else begin
        m_ben = (m_edge == m_next);
        if (m_ben) m_next = m_next + longint'(m_div) + 1;
      end
    end
  end

  function automatic logic [7:0] exp_rdata();
    if (!(bus.i_iocs && bus.i_iorw)) return 8'h00;
    case (bus.i_ioaddr)
      2'd0:    return rx_data;
      2'd1:    return {5'b0, m_drop, rda, tbr};
      2'd2:    return m_div[7:0];
      default: return m_div[15:8];
    endcase
  endfunction

  // Compare every cycle once the model has seen a reset edge.
  always @(negedge clk) begin
    if (m_valid && rst) begin
      check("b_en",    b_en,    m_ben);
      check("tx_load", tx_load, m_txload);
      check("tx_data", tx_data, m_txdata);
      check("rx_iocs", rx_iocs, m_clr);
      check("rx_iorw", rx_iorw, m_clr);
      check("rdata",   bus.o_rdata, exp_rdata());
    end
  end

  // ---------------- stimulus helpers (start/end at posedge+2) ----------------
  task automatic acc(input bit rw, input logic [1:0] a, input logic [7:0] d, output logic [7:0] r);
    bus.i_iocs = 1'b1; bus.i_iorw = rw; bus.i_ioaddr = a; bus.i_wdata = d;
    #2 r = bus.o_rdata;
    @(posedge clk); #2;
    bus.i_iocs = 1'b0; bus.i_iorw = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    acc(1'b0, a, d, dummy);
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] r);
    acc(1'b1, a, 8'h00, r);
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_ben(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!b_en && n < 70000);
  endtask

  initial begin
    int         n;
    logic [7:0] r;
    bus.i_iocs = 0; bus.i_iorw = 0; bus.i_ioaddr = 0; bus.i_wdata = 0;
    rx_data = 0; rda = 0; tbr = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Reset state and default period
    check("rst_tx_load", tx_load, 0);
    check("rst_rx_iocs", rx_iocs, 0);
    wait_ben(n); check("first_ben_cycles", n, 326);
    wait_ben(n); check("default_period", n, 326);

    // DBL alone keeps the period; DBH commits 0x0004
    wr(ADDR_DBL, 8'h04);
    wait_ben(n); wait_ben(n); check("dbl_only_period", n, 326);
    wr(ADDR_DBH, 8'h00);
    wait_ben(n); check("dbh_first_tick", n, 5);
    wait_ben(n); check("dbh_period", n, 5);

    // TX load and drop
    tbr = 1;
    wr(ADDR_DATA, 8'hA5);
    check("tx_load_pulse", tx_load, 1);
    check("tx_data_a5", tx_data, 8'hA5);
    step();
    check("tx_load_once", tx_load, 0);
    tbr = 0;
    wr(ADDR_DATA, 8'h3C);
    check("tx_drop_noload", tx_load, 0);
    check("tx_data_kept", tx_data, 8'hA5);
    rd(ADDR_STATUS, r); check("status_drop", r, 8'h04);
    rd(ADDR_STATUS, r); check("status_cleared", r, 8'h00);

    // RX clear with divisor 7
    wr(ADDR_DBL, 8'h07); wr(ADDR_DBH, 8'h00);
    rda = 1; rx_data = 8'h5A;
    rd(ADDR_DATA, r); check("rx_data_read", r, 8'h5A);
    check("clr_asserted", rx_iocs, 1);
    rd(ADDR_DATA, r);
    n = 1;
    while (rx_iocs && n < 40) begin step(); n++; end
    check("clr_len_bounded", (n <= 8), 1);
    rda = 0;
    step();

    // RX clear with divisor 0: one cycle exactly
    wr(ADDR_DBL, 8'h00); wr(ADDR_DBH, 8'h00);
    rda = 1;
    rd(ADDR_DATA, r);
    n = 0;
    repeat (4) begin if (rx_iocs) n++; step(); end
    check("clr_len_div0", n, 1);
    rda = 0;
    rd(ADDR_DATA, r);
    n = 0;
    repeat (3) begin if (rx_iocs) n++; step(); end
    check("no_clr_without_rda", n, 0);

    // Reset in the middle of CLR_WAIT with a pending shadow and drop flag
    wr(ADDR_DBL, 8'h07); wr(ADDR_DBH, 8'h00);
    tbr = 0; wr(ADDR_DATA, 8'h11);
    wr(ADDR_DBL, 8'h33);
    rda = 1; rd(ADDR_DATA, r);
    check("clr_before_rst", rx_iocs, 1);
    rst = 0; @(posedge clk); #2 rst = 1;
    rda = 0;
    check("rst_mid_clr_iocs", rx_iocs, 0);
    check("rst_mid_clr_iorw", rx_iorw, 0);
    check("rst_tx_data", tx_data, 8'h00);
    rd(ADDR_STATUS, r); check("rst_status", r, 8'h00);
    rd(ADDR_DBL, r); check("rst_div_lo", r, 8'h45);
    rd(ADDR_DBH, r); check("rst_div_hi", r, 8'h01);
    wr(ADDR_DBH, 8'h01);
    rd(ADDR_DBL, r); check("rst_shadow_zero", r, 8'h00);
    rd(ADDR_DBH, r); check("new_div_hi", r, 8'h01);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bus.i_iocs   = $urandom_range(0, 1);
      bus.i_iorw   = $urandom_range(0, 1);
      bus.i_ioaddr = 2'($urandom_range(0, 3));
      bus.i_wdata  = 8'($urandom);
      if (bus.i_ioaddr == ADDR_DBH) bus.i_wdata = ($urandom_range(0, 9) == 0) ? 8'h01 : 8'h00;
      if (bus.i_ioaddr == ADDR_DBL) bus.i_wdata = 8'($urandom_range(0, 20));
      tbr     = $urandom_range(0, 1);
      rda     = $urandom_range(0, 1);
      rx_data = 8'($urandom);
      rst     = ($urandom_range(0, 199) != 0);
      step();
    end
    rst = 1; bus.i_iocs = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spart_ctrl.md
Name: spart_ctrl

Overview:
- Bus-side controller and baud scheduler for the SPART.
- Decodes processor I/O accesses (data, status, divisor low, divisor high) and generates the shared b_en baud tick (16x oversample) for the receiver and transmitter.
- Stretches the processor's RX-read strobe so the receiver, which only samples on b_en, reliably clears its data-available flag.
- Sits between the processor I/O port and the receive/transmit engines.

Parameters:
- DEFAULT_DIV, 16'd325, divisor loaded at reset; b_en period = DEFAULT_DIV+1 clk cycles (50 MHz, 9600 baud x16).
- DATA_W, 8, data bus width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- i_iocs  in  1  I/O chip select from processor
- i_iorw  in  1  1 = read, 0 = write
- i_ioaddr  in  2  00 data, 01 status, 10 divisor low (DBL), 11 divisor high (DBH)
- i_wdata  in  DATA_W  processor write data
- o_rdata  out  DATA_W  processor read data (combinational mux)
- o_b_en  out  1  baud tick to rx/tx engines
- i_rx_data  in  DATA_W  received byte from receiver
- i_rda  in  1  receiver data-available
- o_rx_iocs  out  1  stretched read-clear chip select to receiver
- o_rx_iorw  out  1  stretched read-clear rw to receiver (1 while o_rx_iocs = 1, else 0)
- i_tbr  in  1  transmitter buffer ready
- o_tx_load  out  1  one-cycle load strobe to transmitter
- o_tx_data  out  DATA_W  byte to transmit, registered

Behaviour:
- Reset (rst = 0 at posedge) state:
  - divisor = DEFAULT_DIV; DBL shadow = 0; baud counter = DEFAULT_DIV.
  - o_b_en = 0, o_tx_load = 0, o_tx_data = 0, o_rx_iocs = 0, o_rx_iorw = 0, tx_drop = 0, FSM = IDLE.
  - Reset wins over any simultaneous access.
- Baud generator:
  - 16-bit down-counter. When the count is 0, o_b_en = 1 (registered, one clk wide) and the counter reloads the divisor; otherwise it decrements.
  - Divisor 0 gives o_b_en every cycle. Divisor 0xFFFF gives a period of 65536.
- Divisor writes:
  - A DBL write (iocs=1, iorw=0, addr=10) stores i_wdata into the DBL shadow only. The active divisor is unchanged.
  - A DBH write commits {i_wdata, shadow} atomically as the divisor and reloads the counter with the new value in the same edge. The next o_b_en occurs new_div+1 cycles later.
  - Reading addr 10/11 returns the active divisor low/high byte.
- Reads (iocs=1, iorw=1) return:
  - addr 00: i_rx_data
  - addr 01: {5'b0, tx_drop, i_rda, i_tbr}
  - When iocs = 0, o_rdata = 0.
- tx_drop flag:
  - Cleared on any status read.
  - Set in the same cycle as a read and a drop event: set wins.
- TX write (iocs=1, iorw=0, addr=00):
  - If i_tbr = 1: o_tx_data <= i_wdata and o_tx_load = 1 for exactly one cycle (registered, next edge).
  - If i_tbr = 0: the write is dropped, tx_drop is set (sticky) and o_tx_load stays 0.
  - Back-to-back writes each take effect only while i_tbr = 1.
- RX clear FSM (states IDLE, CLR_WAIT):
  - IDLE: a data read (addr 00, iorw=1, iocs=1) with i_rda = 1 asserts o_rx_iocs/o_rx_iorw from the next edge and moves to CLR_WAIT.
  - CLR_WAIT: outputs held. On the first cycle with o_b_en = 1, outputs are still high that cycle, then deassert and return to IDLE at the next edge.
  - Further reads while in CLR_WAIT are ignored (no extension).
  - A data read with i_rda = 0 does not leave IDLE.
- Accesses with iocs = 0 have no side effects.

Decomposition:
- Package spart_pkg:
  - Address localparams ADDR_DATA = 2'b00, ADDR_STATUS = 2'b01, ADDR_DBL = 2'b10, ADDR_DBH = 2'b11.
  - Status bit indices (STAT_TBR = 0, STAT_RDA = 1, STAT_TXDROP = 2).
  - RX-clear FSM state enum.
- One sub-module, spart_baud_gen:
  - Inputs clk, rst, divisor[15:0], reload.
  - Output b_en.
  - Contains the down-counter.
- All decode logic, tx_drop and the FSM stay in spart_ctrl.

Test Plan:
- Reset release, no access → first o_b_en at cycle 326 after release, then every 326 cycles; all other outputs 0.
- Write DBL=0x04 then DBH=0x00 → o_b_en period becomes 5 cycles starting 5 cycles after the DBH edge; a DBL write alone leaves the period at 326.
- i_tbr=1, write 0xA5 to addr 00 → o_tx_data=0xA5, o_tx_load high exactly 1 cycle. Then i_tbr=0, write 0x3C → no load; status read = 0x04, and a second status read shows bit2 = 0.
- Divisor = 7, i_rda=1, i_rx_data=0x5A, read addr 00 → o_rdata=0x5A. o_rx_iocs/o_rx_iorw stay high through the next o_b_en cycle, then drop; a second read during CLR_WAIT does not extend them.
- Divisor = 0 (b_en every cycle), data read with i_rda=1 → o_rx_iocs high for exactly 1 cycle. A read with i_rda=0 → o_rx_iocs stays 0.
- Assert rst=0 mid CLR_WAIT and after a DBL write → next cycle o_rx_iocs=0, divisor back to 325, shadow 0, tx_drop 0.
